// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/halfAdder.sv
// One-bit half adder cell.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder (two half adders + registered carry)
// iterated LSB first, with valid/ready handshakes on both sides.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             ha0_s, ha0_c, ha1_s, ha1_c;
  logic             accept;

  halfAdder ha0 (.a(a_sh[0]), .b(b_sh[0]), .sum(ha0_s), .carry(ha0_c));
  halfAdder ha1 (.a(ha0_s),   .b(carry),   .sum(ha1_s), .carry(ha1_c));

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)              state_nxt = RUN;
      RUN:     if (bit_cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (out_ready)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Sum enters at the MSB so after WIDTH shifts bit 0 lands in sum_sh[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= op_b;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= WIDTH'({ha1_s, sum_sh} >> 1);
      carry   <= ha0_c | ha1_c;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sh;
  assign cout      = carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [W-1:0] op_a, op_b, sum;
  int           n_cmp = 0;
  int           n_mis = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; noise keeps in_valid high with random operands during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit noise);
    logic [W:0] exp_v;
    int         lat;
    exp_v = {1'b0, a} + {1'b0, b};
    chk("in_ready_pre", in_ready, 1);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, W);
    chk("sum", sum, exp_v[W-1:0]);
    chk("cout", cout, exp_v[W]);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, exp_v[W-1:0]);
      chk("bp_cout", cout, exp_v[W]);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_sum_hold", sum, exp_v[W-1:0]);
    chk("post_cout_hold", cout, exp_v[W]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #3;
    check_reset_state("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("idle");

    run_op(8'h5A, 8'h3C, 0, 1'b0);
    run_op(8'hFF, 8'h01, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'hA5, 8'hC3, 5, 1'b0);
    run_op(8'h77, 8'h99, 1, 1'b1);

    // Reset mid-RUN discards the operation.
    in_valid = 1'b1; op_a = 8'hF0; op_b = 8'h3F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("midrun");
    @(posedge clk); #1;
    check_reset_state("midrun_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h12, 8'h34, 0, 1'b0);
    run_op(8'h00, 8'h00, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
